// File: rtl/deserializer.sv
// Bit-serial to parallel converter: packs MSB-first bits into DATA_W words; partial words
// flush on ser_last_i, or on an idle gap when DESER_TIMEOUT_EN is defined.
module deserializer #(
  parameter int DATA_W      = 16,
  parameter int MOD_W       = $clog2(DATA_W),
  parameter int GAP_TIMEOUT = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  input  logic              ser_last_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  localparam logic [MOD_W:0] FULL = (MOD_W+1)'(DATA_W);

  logic [DATA_W-1:0] sr, sr_nxt, word_aligned;
  logic [MOD_W-1:0]  cnt;
  logic [MOD_W:0]    cnt_nxt;
  logic              flush, full_done, part_done;

  always_comb begin
    sr_nxt  = sr;
    cnt_nxt = {1'b0, cnt};
    if (ser_data_val_i) begin
      sr_nxt  = {sr[DATA_W-2:0], ser_data_i};
      cnt_nxt = cnt_nxt + 1'b1;
    end
  end

  // Partial word is left-aligned so the first bit lands at the MSB.
  assign word_aligned = sr_nxt << (FULL - cnt_nxt);
  assign full_done    = (cnt_nxt == FULL);
  assign part_done    = flush && (cnt_nxt != '0) && !full_done;

`ifdef DESER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(GAP_TIMEOUT + 1);
  logic [IDLE_W-1:0] idle;

  assign flush = ser_last_i || (idle == IDLE_W'(GAP_TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                   idle <= '0;
    else if (cnt == '0 || ser_data_val_i || flush)  idle <= '0;
    else                                            idle <= idle + 1'b1;
  end
`else
  assign flush = ser_last_i;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr               <= '0;
      cnt              <= '0;
      deser_data_o     <= '0;
      deser_mod_o      <= '0;
      deser_data_val_o <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      busy_o           <= 1'b0;
      if (full_done) begin
        deser_data_o     <= sr_nxt;
        deser_mod_o      <= '0;
        deser_data_val_o <= 1'b1;
        sr               <= '0;
        cnt              <= '0;
      end else if (part_done) begin
        deser_data_o     <= word_aligned;
        deser_mod_o      <= cnt_nxt[MOD_W-1:0];
        deser_data_val_o <= 1'b1;
        sr               <= '0;
        cnt              <= '0;
      end else begin
        sr     <= sr_nxt;
        cnt    <= cnt_nxt[MOD_W-1:0];
        busy_o <= (cnt_nxt != '0);
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Randomised + directed bench for deserializer against a bit-queue reference model.
module tb_deserializer;
  localparam int W   = 16;
  localparam int MW  = 4;
  localparam int GAP = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          ser_data_i = 1'b0, ser_data_val_i = 1'b0, ser_last_i = 1'b0;
  logic [W-1:0]  deser_data_o;
  logic [MW-1:0] deser_mod_o;
  logic          deser_data_val_o, busy_o;

  deserializer #(.DATA_W(W), .MOD_W(MW), .GAP_TIMEOUT(GAP)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .ser_data_i(ser_data_i),
    .ser_data_val_i(ser_data_val_i), .ser_last_i(ser_last_i),
    .deser_data_o(deser_data_o), .deser_mod_o(deser_mod_o),
    .deser_data_val_o(deser_data_val_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_bad = 0;
  int strobes = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: received bits kept as a queue, words built from it directly.
  bit          mq[$];
  int          idle = 0;
  logic [W-1:0] e_data = '0;
  int          e_mod = 0;
  bit          e_val = 0;

  function automatic void model_step(bit v, bit d, bit l);
    int  n_before = mq.size();
    bit  to = 0;
    bit  fl = 0;
`ifdef DESER_TIMEOUT_EN
    to = (idle == GAP);
`endif
    e_val = 0;
    if (v) mq.push_back(d);
    if (mq.size() == W || ((l || to) && mq.size() > 0)) begin
      e_data = '0;
      foreach (mq[i]) e_data[W-1-i] = mq[i];
      e_mod = mq.size() % W;
      e_val = 1;
      fl = 1;
      mq.delete();
    end
    idle = (n_before > 0 && !v && !fl) ? idle + 1 : 0;
  endfunction

  function automatic void model_reset();
    mq.delete();
    idle = 0; e_data = '0; e_mod = 0; e_val = 0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_val"},  32'(deser_data_val_o), 32'(e_val));
    chk({tag, "_data"}, 32'(deser_data_o),     32'(e_data));
    chk({tag, "_mod"},  32'(deser_mod_o),      32'(e_mod));
    chk({tag, "_busy"}, 32'(busy_o),           32'(mq.size() != 0));
  endtask

  // One clock: drive at negedge, update model at posedge, compare at next negedge.
  task automatic cyc(input bit v, input bit d, input bit l, input string tag);
    ser_data_val_i = v; ser_data_i = d; ser_last_i = l;
    @(posedge clk_i);
    model_step(v, d, l);
    @(negedge clk_i);
    if (deser_data_val_o) strobes++;
    check_all(tag);
  endtask

  task automatic send_word(input logic [W-1:0] w, input string tag);
    for (int i = W - 1; i >= 0; i--) cyc(1'b1, w[i], 1'b0, tag);
  endtask

  initial begin
    int last_strobe;
    int exp_to;
    logic [2:0] pat5;

    // Reset state
    #12;
    chk("rst_data", 32'(deser_data_o), 32'h0);
    chk("rst_mod",  32'(deser_mod_o),  32'h0);
    chk("rst_val",  32'(deser_data_val_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Full word
    send_word(16'hA5C3, "full");
    chk("full_word", 32'(deser_data_o), 32'hA5C3);
    chk("full_modz", 32'(deser_mod_o), 32'h0);
    cyc(0, 0, 0, "full_after");
    chk("full_busy_after", 32'(busy_o), 32'h0);

    // Partial flush 1,0,1,1,0 with last on the 5th bit
    cyc(1, 1, 0, "part"); cyc(1, 0, 0, "part"); cyc(1, 1, 0, "part"); cyc(1, 1, 0, "part");
    cyc(1, 0, 1, "part");
    chk("part_word", 32'(deser_data_o), 32'hB000);
    chk("part_mod",  32'(deser_mod_o),  32'd5);
    cyc(0, 0, 0, "part_after");

    // Streaming: strobes exactly W cycles apart
    strobes = 0; last_strobe = 0;
    send_word(16'hFFFF, "strm0");
    chk("strm0_word", 32'(deser_data_o), 32'hFFFF);
    send_word(16'h0001, "strm1");
    chk("strm1_word", 32'(deser_data_o), 32'h0001);
    send_word(16'h8000, "strm2");
    chk("strm2_word", 32'(deser_data_o), 32'h8000);
    chk("strm_strobes", 32'(strobes), 32'd3);

    // Stand-alone last with empty word, then 3 ones flushed by a lone last
    cyc(0, 0, 1, "lone_empty");
    chk("lone_empty_nostrobe", 32'(deser_data_val_o), 32'h0);
    cyc(1, 1, 0, "lone"); cyc(1, 1, 0, "lone"); cyc(1, 1, 0, "lone");
    cyc(0, 0, 1, "lone");
    chk("lone_word", 32'(deser_data_o), 32'hE000);
    chk("lone_mod",  32'(deser_mod_o),  32'd3);

    // Asynchronous reset mid-word
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, "prerst");
    #2 rst_n_i = 1'b0;
    #1;
    model_reset();
    chk("arst_data", 32'(deser_data_o), 32'h0);
    chk("arst_mod",  32'(deser_mod_o),  32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    send_word(16'h1234, "postrst");
    chk("postrst_word", 32'(deser_data_o), 32'h1234);
    chk("postrst_mod",  32'(deser_mod_o),  32'h0);

    // Idle-gap behaviour: 1,0,0,1 then a long idle stretch
    cyc(1, 1, 0, "gap"); cyc(1, 0, 0, "gap"); cyc(1, 0, 0, "gap"); cyc(1, 1, 0, "gap");
    strobes = 0;
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, "gap_idle");
`ifdef DESER_TIMEOUT_EN
    exp_to = 1;
    chk("gap_word", 32'(deser_data_o), 32'h9000);
    chk("gap_mod",  32'(deser_mod_o),  32'd4);
`else
    exp_to = 0;
`endif
    chk("gap_strobes", 32'(strobes), 32'(exp_to));
    cyc(0, 0, 1, "gap_clear");

    // Randomised traffic with occasional idle stretches
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 60) == 0) begin
        for (int j = 0; j < int'($urandom_range(5, 12)); j++) cyc(0, 0, 0, "rnd_idle");
      end else begin
        pat5 = 3'($urandom_range(0, 7));
        cyc(pat5 != 3'd0, 1'($urandom), $urandom_range(0, 19) == 0, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
